// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: block geometry, byte type and row-shift index helper.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W  = 128;
  localparam int unsigned AES_BYTE_W   = 8;
  localparam int unsigned AES_NB_BYTES = 16;

  typedef logic [AES_BYTE_W-1:0] state_byte_t;

  // Byte index is column-major (4*col + row); InvShiftRows rotates row r right by r.
  function automatic logic [3:0] inv_shift_src(input logic [3:0] idx);
    logic [1:0] col;
    logic [1:0] row;
    logic [1:0] src_col;
    col     = idx[3:2];
    row     = idx[1:0];
    src_col = col - row;
    return {src_col, row};
  endfunction

endpackage

// File: rtl/inv_sbox_rom.sv
// Combinational 256x8 AES inverse S-box; table contents match inv_sbox.txt.
module inv_sbox_rom
  import aes_pkg::*;
(
  input  state_byte_t i_addr,
  output state_byte_t o_data
);

  // Entry 0 sits in the top byte, so entry a lives at bit offset (255-a)*8.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] w_lsb;

  assign w_lsb  = {~i_addr, 3'b000};
  assign o_data = INV_SBOX[w_lsb +: 8];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes (+ optional InvShiftRows): LANES bytes per cycle, one block in flight.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int unsigned LANES     = 4,
  parameter int unsigned INV_SHIFT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data
);

  localparam int unsigned NBeats = AES_NB_BYTES / LANES;
  localparam int unsigned CntW   = (NBeats > 1) ? $clog2(NBeats) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                 r_state, w_state_nxt;
  logic [CntW-1:0]        r_cnt, w_cnt_nxt;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [AES_BLOCK_W-1:0] r_out_data;
  state_byte_t            r_buf [AES_NB_BYTES];

  state_byte_t            w_in_bytes [AES_NB_BYTES];
  state_byte_t            w_sub [AES_NB_BYTES];
  logic [3:0]             w_lane_idx [LANES];
  state_byte_t            w_sbox_in [LANES];
  state_byte_t            w_sbox_out [LANES];
  logic [AES_BLOCK_W-1:0] w_res;
  logic                   w_load, w_beat, w_fin;

  always_comb begin
    for (int i = 0; i < int'(AES_NB_BYTES); i++) begin
      w_in_bytes[i] = in_data[AES_BLOCK_W-1-8*i -: 8];
    end
  end

  always_comb begin
    for (int j = 0; j < int'(LANES); j++) begin
      w_lane_idx[j] = 4'(32'(r_cnt) * LANES + 32'(j));
      w_sbox_in[j]  = r_buf[w_lane_idx[j]];
    end
  end

  for (genvar gi = 0; gi < int'(LANES); gi++) begin : g_lane
    inv_sbox_rom u_rom (
      .i_addr (w_sbox_in[gi]),
      .o_data (w_sbox_out[gi])
    );
  end

  // Work buffer with this beat's lanes already substituted.
  always_comb begin
    w_sub = r_buf;
    for (int j = 0; j < int'(LANES); j++) begin
      w_sub[w_lane_idx[j]] = w_sbox_out[j];
    end
  end

  always_comb begin
    w_res = '0;
    for (int i = 0; i < int'(AES_NB_BYTES); i++) begin
      if (INV_SHIFT != 0) begin
        w_res[AES_BLOCK_W-1-8*i -: 8] = w_sub[inv_shift_src(4'(i))];
      end else begin
        w_res[AES_BLOCK_W-1-8*i -: 8] = w_sub[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_beat      = 1'b0;
    w_fin       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_valid && r_in_ready) begin
          w_state_nxt = StBusy;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      StBusy: begin
        w_beat    = 1'b1;
        w_cnt_nxt = r_cnt + CntW'(1);
        if (r_cnt == CntW'(NBeats - 1)) begin
          w_state_nxt = StDone;
          w_cnt_nxt   = '0;
          w_fin       = 1'b1;
        end
      end
      StDone: begin
        if (r_out_valid && out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      for (int i = 0; i < int'(AES_NB_BYTES); i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt == StIdle);
      r_out_valid <= (w_state_nxt == StDone);
      if (w_fin) begin
        r_out_data <= w_res;
      end
      if (w_load) begin
        r_buf <= w_in_bytes;
      end else if (w_beat) begin
        r_buf <= w_sub;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Scoreboard bench: six DUT configurations against a GF(2^8)-derived InvSubBytes/InvShiftRows model.
module tb_inv_sub_bytes_iter;

  localparam int NCFG = 6;
  localparam int LANES_C [NCFG] = '{4, 1, 2, 8, 16, 4};
  localparam int SHIFT_C [NCFG] = '{1, 1, 1, 1, 1, 0};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid  [NCFG];
  logic         in_ready  [NCFG];
  logic         out_valid [NCFG];
  logic         out_ready [NCFG];
  logic [127:0] in_data   [NCFG];
  logic [127:0] out_data  [NCFG];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int           g;
    logic [127:0] d;
    int           t;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] fwd_sb [256];
  logic [7:0] inv_sb [256];

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Forward S-box from multiplicative inverse + affine map, then inverted as a lookup.
  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      fwd_sb[x] = s;
      inv_sb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_model(input logic [127:0] d, input int shift);
    logic [7:0]   b [16];
    logic [127:0] o;
    int           src;
    for (int i = 0; i < 16; i++) b[i] = inv_sb[d[127-8*i -: 8]];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = (shift != 0) ? 4 * ((c - r + 4) % 4) + r : 4 * c + r;
        o[127-8*(4*c+r) -: 8] = b[src];
      end
    end
    return o;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    inv_sub_bytes_iter #(
      .LANES     (LANES_C[g]),
      .INV_SHIFT (SHIFT_C[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );

    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic         chk_rdy = 1'b0;
    logic [127:0] pd = '0;

    initial begin
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          pv = 1'b0;
          pr = 1'b0;
          chk_rdy = 1'b0;
        end else begin
          if (chk_rdy) begin
            check($sformatf("in_ready_return[%0d]", g), 128'(in_ready[g]), 128'd1);
            chk_rdy = 1'b0;
          end
          if (out_valid[g] && !pv) begin
            if (sb_q.size() == 0 || sb_q[0].g != g) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_out[%0d]: out_valid=1, required no pending block", g);
            end else begin
              check($sformatf("latency[%0d]", g), 128'(cyc - sb_q[0].t),
                    128'(16 / LANES_C[g]));
            end
          end
          if (out_valid[g] && pv && !pr) check($sformatf("hold[%0d]", g), out_data[g], pd);
          if (out_valid[g]) check($sformatf("in_ready_low[%0d]", g), 128'(in_ready[g]), 128'd0);
          if (out_valid[g] && out_ready[g]) begin
            if (sb_q.size() != 0 && sb_q[0].g == g) begin
              check($sformatf("data[%0d]", g), out_data[g], sb_q[0].d);
              void'(sb_q.pop_front());
              chk_rdy = 1'b1;
            end
          end
          pv = out_valid[g];
          pr = out_ready[g];
          pd = out_data[g];
        end
      end
    end
  end

  task automatic send(input int g, input logic [127:0] d, input logic [127:0] e);
    exp_t x;
    int   w;
    @(posedge clk);
    #1;
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!in_ready[g] && w < 100);
    if (!in_ready[g]) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout[%0d]: in_ready=0, required 1 within 100 cycles", g);
      in_valid[g] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    x.g = g;
    x.d = e;
    x.t = cyc;
    sb_q.push_back(x);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d blocks pending, required 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("%s_in_ready[%0d]", tag, g), 128'(in_ready[g]), 128'd0);
      check($sformatf("%s_out_valid[%0d]", tag, g), 128'(out_valid[g]), 128'd0);
      check($sformatf("%s_out_data[%0d]", tag, g), out_data[g], 128'd0);
    end
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] e;
    logic [127:0] junk;
    int           idx_list [16];
    int           stall;
    int           w;

    idx_list = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
    build_tables();
    for (int g = 0; g < NCFG; g++) begin
      in_valid[g]  = 1'b0;
      in_data[g]   = '0;
      out_ready[g] = 1'b1;
    end

    #2;
    check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_before_edge", 128'(in_ready[0]), 128'd0);
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("in_ready_after_edge[%0d]", g), 128'(in_ready[g]), 128'd1);
    end

    send(0, '0, {16{8'h52}});
    wait_idle();
    send(0, {16{8'h63}}, '0);
    wait_idle();
    send(5, 128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb);
    wait_idle();

    for (int i = 0; i < 16; i++) begin
      d[127-8*i -: 8] = fwd_sb[i];
      e[127-8*i -: 8] = 8'(idx_list[i]);
    end
    send(0, d, e);
    wait_idle();

    // Backpressure with an ignored in_valid during DONE.
    out_ready[0] = 1'b0;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(0, d, ref_model(d, 1));
    w = 0;
    while (!out_valid[0] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("bp_out_valid", 128'(out_valid[0]), 128'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        junk = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid[0] = 1'b1;
        in_data[0]  = junk;
      end
      if (i == 7) in_valid[0] = 1'b0;
    end
    out_ready[0] = 1'b1;
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_capture_in_done", 128'(out_valid[0]), 128'd0);
    end

    for (int g = 0; g < NCFG; g++) begin
      for (int k = 0; k < 8; k++) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        stall = int'($urandom_range(0, 3));
        out_ready[g] = (stall == 0);
        send(g, d, ref_model(d, SHIFT_C[g]));
        if (stall != 0) begin
          repeat (16 / LANES_C[g] + stall) @(posedge clk);
          #1;
          out_ready[g] = 1'b1;
        end
        wait_idle();
      end
    end

    // Reset between the first and second beat of a LANES=4 block.
    send(0, '0, {16{8'h52}});
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0, '0, {16{8'h52}});
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
